// File: rtl/l1b_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// l1b_cycle_ctrl
//
// CPU cycle sequencer and memory mapper for the L1B main CPLD. It generates
// the 65816 clock (cpu_phi2) from hsclk and latches the bank byte at the end
// of every low phase. Each cycle is classed as:
//   - fast: local SRAM, or an invalid cycle with no strobes;
//   - slow: a host-bus cycle, stretched so that the high phase lines up with
//     the synchronised BBC phase-0 clock.
// It also holds local mirrors of the shadow-enable and ROM-select registers.
// These are written through the dec_* strobes from the address-decode CPLD.
//
// Parameters
//   LO_CYCLES   : hsclk periods in every cpu_phi2 low phase (>= 2)
//   HI_CYCLES   : hsclk periods in a fast cpu_phi2 high phase (>= 2)
//   SYNC_STAGES : flops in the bbc_phi0 synchroniser (>= 1)
//
// Ports
//   hsclk          in   sole clock
//   resetb         in   asynchronous active-low reset
//   bbc_phi0       in   host phase-0 clock, asynchronous to hsclk
//   cpu_d[7:0]     in   CPU data: bank byte while cpu_phi2=0, write data high
//   cpu_a[15:0]    in   CPU address
//   cpu_vda        in   valid data address
//   cpu_vpa        in   valid program address
//   cpu_rnw        in   1 = read, 0 = write
//   dec_fe4x       in   decode of &FE4x
//   dec_shadow_reg in   decode of the shadow-enable register
//   dec_rom_reg    in   decode of ROMSEL
//   cpu_phi2       out  CPU clock
//   bank[7:0]      out  latched bank byte
//   ram_a[4:0]     out  SRAM A18..A14
//   ram_ceb        out  SRAM chip enable, active low
//   ram_oeb        out  SRAM output enable, active low
//   ram_web        out  SRAM write enable, active low
//   bbc_cycle      out  host-bus cycle in progress
//   shadow_en      out  shadow-enable mirror
//   rom_sel[3:0]   out  ROM-select mirror
// ---------------------------------------------------------------------------
module l1b_cycle_ctrl #(
  parameter int LO_CYCLES   = 2,
  parameter int HI_CYCLES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        hsclk,
  input  logic        resetb,
  input  logic        bbc_phi0,
  input  logic [7:0]  cpu_d,
  input  logic [15:0] cpu_a,
  input  logic        cpu_vda,
  input  logic        cpu_vpa,
  input  logic        cpu_rnw,
  input  logic        dec_fe4x,
  input  logic        dec_shadow_reg,
  input  logic        dec_rom_reg,
  output logic        cpu_phi2,
  output logic [7:0]  bank,
  output logic [4:0]  ram_a,
  output logic        ram_ceb,
  output logic        ram_oeb,
  output logic        ram_web,
  output logic        bbc_cycle,
  output logic        shadow_en,
  output logic [3:0]  rom_sel
);

  localparam int CntMax = (LO_CYCLES > HI_CYCLES) ? LO_CYCLES : HI_CYCLES;
  localparam int CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] LoLast = CntW'(LO_CYCLES - 1);
  localparam logic [CntW-1:0] HiLast = CntW'(HI_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LO        = 2'd0,
    ST_HI        = 2'd1,
    ST_SLOW_WAIT = 2'd2,
    ST_SLOW_HI   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   phiPrev_q;

  logic [7:0] bank_q, bank_d;
  logic [4:0] ramA_q, ramA_d;
  logic       ramCycle_q, ramCycle_d;
  logic       shPend_q, shPend_d;
  logic       romPend_q, romPend_d;
  logic       shadow_q, shadow_d;
  logic [3:0] rom_q, rom_d;

  logic       phi2_q, phi2_d;
  logic       bbc_q, bbc_d;
  logic       ceb_q, ceb_d;
  logic       oeb_q, oeb_d;
  logic       web_q, web_d;

  logic       phiSync;
  logic       phiRise;
  logic       phiFall;

  logic       cycValid;
  logic       bankZero;
  logic       shadowHit;
  logic       regWrite;
  logic       isRam;
  logic       isSlow;
  logic [4:0] mapA;

  // Only A15/A14 take part in the mapping; the rest of the address bus is
  // decoded by the other CPLD.
  logic       unusedAddrBits;
  assign unusedAddrBits = ^cpu_a[13:0];

  // bbc_phi0 is asynchronous to hsclk, so it passes through a flop chain.
  // Edges are detected on the last stage against a delayed copy of it.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      sync_q    <= '0;
      phiPrev_q <= 1'b0;
    end else begin
      sync_q[0] <= bbc_phi0;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      phiPrev_q <= phiSync;
    end
  end

  assign phiSync = sync_q[SYNC_STAGES-1];
  assign phiRise = phiSync & ~phiPrev_q;
  assign phiFall = ~phiSync & phiPrev_q;

  // Cycle decode. It looks at cpu_d directly, because it is evaluated on the
  // same edge that latches the bank byte. Writes to the mirrored registers
  // are always forced onto the host bus, so the host sees them too.
  always_comb begin
    cycValid  = cpu_vda | cpu_vpa;
    bankZero  = (cpu_d == 8'h00);
    shadowHit = bankZero & ~cpu_a[15] & shadow_q & ~dec_fe4x;
    regWrite  = bankZero & ~cpu_rnw & cpu_vda & (dec_shadow_reg | dec_rom_reg);
    isRam     = cycValid & ~regWrite & (~bankZero | shadowHit);
    isSlow    = cycValid & ~isRam;
    if (shadowHit) begin
      mapA = {3'b111, cpu_a[15], cpu_a[14]};
    end else begin
      mapA = {cpu_d[2:0], cpu_a[15], cpu_a[14]};
    end
  end

  // Next-state logic for the sequencer. Outputs are derived from the next
  // state so that they change on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    ramA_d     = ramA_q;
    ramCycle_d = ramCycle_q;
    shPend_d   = shPend_q;
    romPend_d  = romPend_q;
    shadow_d   = shadow_q;
    rom_d      = rom_q;

    case (state_q)
      ST_LO: begin
        if (cnt_q == LoLast) begin
          cnt_d      = '0;
          bank_d     = cpu_d;
          ramA_d     = mapA;
          ramCycle_d = isRam;
          shPend_d   = regWrite & dec_shadow_reg;
          romPend_d  = regWrite & dec_rom_reg;
          state_d    = isSlow ? ST_SLOW_WAIT : ST_HI;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      ST_HI: begin
        if (cnt_q == HiLast) begin
          cnt_d   = '0;
          state_d = ST_LO;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // A level that is already high on entry gives no rise here. That
      // forces a wait for a complete low-to-high transition.
      ST_SLOW_WAIT: begin
        cnt_d = '0;
        if (phiRise) begin
          state_d = ST_SLOW_HI;
        end
      end

      // Write data is valid for the whole high phase. The mirrors therefore
      // capture on the transition back to LO.
      ST_SLOW_HI: begin
        cnt_d = '0;
        if (phiFall) begin
          state_d = ST_LO;
          if (shPend_q) begin
            shadow_d = cpu_d[0];
          end
          if (romPend_q) begin
            rom_d = cpu_d[3:0];
          end
          shPend_d  = 1'b0;
          romPend_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state. ram_web is released on the last HI
  // clock so that write data is held past the end of the write strobe.
  always_comb begin
    phi2_d = (state_d == ST_HI) || (state_d == ST_SLOW_HI);
    bbc_d  = (state_d == ST_SLOW_WAIT) || (state_d == ST_SLOW_HI);
    ceb_d  = !((state_d == ST_HI) && ramCycle_d);
    oeb_d  = !((state_d == ST_HI) && ramCycle_d && cpu_rnw);
    web_d  = !((state_d == ST_HI) && ramCycle_d && !cpu_rnw && (cnt_d != HiLast));
  end

  // State, cycle-context and output registers. Reset aborts any cycle and
  // strobe at once.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_LO;
      cnt_q      <= '0;
      bank_q     <= 8'h00;
      ramA_q     <= 5'd0;
      ramCycle_q <= 1'b0;
      shPend_q   <= 1'b0;
      romPend_q  <= 1'b0;
      shadow_q   <= 1'b0;
      rom_q      <= 4'h0;
      phi2_q     <= 1'b0;
      bbc_q      <= 1'b0;
      ceb_q      <= 1'b1;
      oeb_q      <= 1'b1;
      web_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      ramA_q     <= ramA_d;
      ramCycle_q <= ramCycle_d;
      shPend_q   <= shPend_d;
      romPend_q  <= romPend_d;
      shadow_q   <= shadow_d;
      rom_q      <= rom_d;
      phi2_q     <= phi2_d;
      bbc_q      <= bbc_d;
      ceb_q      <= ceb_d;
      oeb_q      <= oeb_d;
      web_q      <= web_d;
    end
  end

  assign cpu_phi2  = phi2_q;
  assign bank      = bank_q;
  assign ram_a     = ramA_q;
  assign ram_ceb   = ceb_q;
  assign ram_oeb   = oeb_q;
  assign ram_web   = web_q;
  assign bbc_cycle = bbc_q;
  assign shadow_en = shadow_q;
  assign rom_sel   = rom_q;

endmodule

// File: tb/tb_l1b_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l1b_cycle_ctrl
//
// Scoreboard bench for l1b_cycle_ctrl.
//
// The stimulus thread acts as the CPU. It drives one bus cycle per
// applyStimulus call and pushes the hand-computed expectation for that cycle.
//
// A monitor samples on every hsclk falling edge. On each cpu_phi2 high-to-low
// transition it closes the cycle record, pops the expectation and compares.
//
// bbc_phi0 runs free at hsclk/8, which is the 2 MHz host clock against a
// 16 MHz hsclk.
// ---------------------------------------------------------------------------
module tb_l1b_cycle_ctrl;

  localparam int LoCycles   = 2;
  localparam int HiCycles   = 2;
  localparam int SyncStages = 2;
  localparam int EdgeLag    = SyncStages + 1;

  logic        hsclk;
  logic        resetb;
  logic        bbc_phi0;
  logic [7:0]  cpu_d;
  logic [15:0] cpu_a;
  logic        cpu_vda, cpu_vpa, cpu_rnw;
  logic        dec_fe4x, dec_shadow_reg, dec_rom_reg;
  logic        cpu_phi2;
  logic [7:0]  bank;
  logic [4:0]  ram_a;
  logic        ram_ceb, ram_oeb, ram_web;
  logic        bbc_cycle;
  logic        shadow_en;
  logic [3:0]  rom_sel;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int id;
    bit slow;
    int ceb;
    int oeb;
    int web;
    bit chkRamA;
    int ramA;
    int bank;
    int shadow;
    int romSel;
  } expT;

  expT expQ[$];

  l1b_cycle_ctrl #(
    .LO_CYCLES  (LoCycles),
    .HI_CYCLES  (HiCycles),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .hsclk         (hsclk),
    .resetb        (resetb),
    .bbc_phi0      (bbc_phi0),
    .cpu_d         (cpu_d),
    .cpu_a         (cpu_a),
    .cpu_vda       (cpu_vda),
    .cpu_vpa       (cpu_vpa),
    .cpu_rnw       (cpu_rnw),
    .dec_fe4x      (dec_fe4x),
    .dec_shadow_reg(dec_shadow_reg),
    .dec_rom_reg   (dec_rom_reg),
    .cpu_phi2      (cpu_phi2),
    .bank          (bank),
    .ram_a         (ram_a),
    .ram_ceb       (ram_ceb),
    .ram_oeb       (ram_oeb),
    .ram_web       (ram_web),
    .bbc_cycle     (bbc_cycle),
    .shadow_en     (shadow_en),
    .rom_sel       (rom_sel)
  );

  // 16 MHz-style hsclk with rising edges at 5, 15, 25 ...
  initial begin
    hsclk = 1'b0;
    forever #5 hsclk = ~hsclk;
  end

  // Host phase-0 runs at hsclk/8. It toggles 2 ns after a rising edge so that
  // its phase is deterministic.
  initial begin
    bbc_phi0 = 1'b0;
    forever begin
      repeat (4) @(posedge hsclk);
      #2 bbc_phi0 = ~bbc_phi0;
    end
  end

  // Single comparison point shared by the monitor and the stimulus thread.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic expT mkExp(input int id, input bit slow, input int ceb, input int oeb,
                                input int web, input bit chkRamA, input int ramA,
                                input int bnk, input int sh, input int rom);
    expT e;
    e.id = id; e.slow = slow; e.ceb = ceb; e.oeb = oeb; e.web = web;
    e.chkRamA = chkRamA; e.ramA = ramA; e.bank = bnk; e.shadow = sh; e.romSel = rom;
    return e;
  endfunction

  // Bounded wait for a cpu_phi2 level, sampled on falling edges.
  task automatic waitPhi2(input logic level, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge hsclk);
      n++;
    end while ((cpu_phi2 !== level) && (n < 200));
    checkOutput($sformatf("%s.phi2Reached", tag), int'(cpu_phi2 === level), 1);
  endtask

  // One CPU bus cycle. This task is called at the start of a low phase.
  task automatic applyStimulus(input logic [7:0] bnk, input logic [15:0] addr,
                               input logic rnw, input logic vda, input logic vpa,
                               input logic fe4x, input logic shReg, input logic romReg,
                               input logic [7:0] wdata, input expT e);
    expQ.push_back(e);
    cpu_d          = bnk;
    cpu_a          = addr;
    cpu_rnw        = rnw;
    cpu_vda        = vda;
    cpu_vpa        = vpa;
    dec_fe4x       = fe4x;
    dec_shadow_reg = shReg;
    dec_rom_reg    = romReg;
    waitPhi2(1'b1, $sformatf("cyc%0d.rise", e.id));
    cpu_d = wdata;
    waitPhi2(1'b0, $sformatf("cyc%0d.fall", e.id));
  endtask

  // Monitor: measures each cycle and checks it against the scoreboard.
  int  sampleIdx   = 0;
  int  bbcRiseIdx  = 0;
  int  bbcFallIdx  = 0;
  bit  prevBbc     = 1'b0;
  bit  prevPhi2    = 1'b0;
  int  lowCnt      = 0;
  int  highCnt     = 0;
  int  cebCnt      = 0;
  int  oebCnt      = 0;
  int  webCnt      = 0;
  int  bbcCnt      = 0;
  int  riseLag     = 0;
  int  ramAHi      = 0;
  int  bankHi      = 0;

  initial begin
    expT e;
    forever begin
      @(negedge hsclk);
      sampleIdx++;
      if (bbc_phi0 && !prevBbc) bbcRiseIdx = sampleIdx;
      if (!bbc_phi0 && prevBbc) bbcFallIdx = sampleIdx;
      prevBbc = bbc_phi0;
      if (!resetb) begin
        lowCnt = 0; highCnt = 0; cebCnt = 0; oebCnt = 0; webCnt = 0; bbcCnt = 0;
        prevPhi2 = 1'b0;
      end else begin
        if (prevPhi2 && !cpu_phi2) begin
          checkOutput("cycleExpected", int'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.slow) begin
              checkOutput($sformatf("cyc%0d.riseLag", e.id), riseLag, EdgeLag);
              checkOutput($sformatf("cyc%0d.fallLag", e.id), sampleIdx - bbcFallIdx, EdgeLag);
              checkOutput($sformatf("cyc%0d.bbcClocks", e.id), bbcCnt, lowCnt - LoCycles + highCnt);
            end else begin
              checkOutput($sformatf("cyc%0d.lowClocks", e.id), lowCnt, LoCycles);
              checkOutput($sformatf("cyc%0d.highClocks", e.id), highCnt, HiCycles);
              checkOutput($sformatf("cyc%0d.bbcClocks", e.id), bbcCnt, 0);
            end
            checkOutput($sformatf("cyc%0d.cebClocks", e.id), cebCnt, e.ceb);
            checkOutput($sformatf("cyc%0d.oebClocks", e.id), oebCnt, e.oeb);
            checkOutput($sformatf("cyc%0d.webClocks", e.id), webCnt, e.web);
            if (e.chkRamA) checkOutput($sformatf("cyc%0d.ramA", e.id), ramAHi, e.ramA);
            checkOutput($sformatf("cyc%0d.bank", e.id), bankHi, e.bank);
            checkOutput($sformatf("cyc%0d.shadowEn", e.id), int'(shadow_en), e.shadow);
            checkOutput($sformatf("cyc%0d.romSel", e.id), int'(rom_sel), e.romSel);
          end
          lowCnt = 0; highCnt = 0; cebCnt = 0; oebCnt = 0; webCnt = 0; bbcCnt = 0;
        end
        if (!prevPhi2 && cpu_phi2) riseLag = sampleIdx - bbcRiseIdx;
        if (cpu_phi2) begin
          highCnt++;
          ramAHi = int'(ram_a);
          bankHi = int'(bank);
        end else begin
          lowCnt++;
        end
        if (!ram_ceb) cebCnt++;
        if (!ram_oeb) oebCnt++;
        if (!ram_web) webCnt++;
        if (bbc_cycle) bbcCnt++;
        prevPhi2 = cpu_phi2;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    resetb = 1'b0;
    cpu_d = 8'h00; cpu_a = 16'h0000; cpu_rnw = 1'b1; cpu_vda = 1'b0; cpu_vpa = 1'b0;
    dec_fe4x = 1'b0; dec_shadow_reg = 1'b0; dec_rom_reg = 1'b0;

    repeat (2) @(posedge hsclk);
    @(posedge hsclk);
    #2;
    checkOutput("rst.cpuPhi2", int'(cpu_phi2), 0);
    checkOutput("rst.bank", int'(bank), 0);
    checkOutput("rst.ramA", int'(ram_a), 0);
    checkOutput("rst.ramCeb", int'(ram_ceb), 1);
    checkOutput("rst.ramOeb", int'(ram_oeb), 1);
    checkOutput("rst.ramWeb", int'(ram_web), 1);
    checkOutput("rst.bbcCycle", int'(bbc_cycle), 0);
    checkOutput("rst.shadowEn", int'(shadow_en), 0);
    checkOutput("rst.romSel", int'(rom_sel), 0);
    #2 resetb = 1'b1;

    // bank &01, &2000 read: fast RAM
    applyStimulus(8'h01, 16'h2000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                  mkExp(1, 1'b0, 2, 2, 0, 1'b1, 5'b00100, 8'h01, 0, 0));
    // bank 0, &FE40 read: slow host cycle
    applyStimulus(8'h00, 16'hFE40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,
                  mkExp(2, 1'b1, 0, 0, 0, 1'b0, 0, 8'h00, 0, 0));
    // write &01 to the shadow register: slow, shadow_en set afterwards
    applyStimulus(8'h00, 16'hFE34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01,
                  mkExp(3, 1'b1, 0, 0, 0, 1'b0, 0, 8'h00, 1, 0));
    // bank 0, &3000 read with shadow: fast, aliases bank 7
    applyStimulus(8'h00, 16'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                  mkExp(4, 1'b0, 2, 2, 0, 1'b1, 5'b11100, 8'h00, 1, 0));
    // write &0C to ROMSEL: slow, shadow_en unchanged
    applyStimulus(8'h00, 16'hFE30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0C,
                  mkExp(5, 1'b1, 0, 0, 0, 1'b0, 0, 8'h00, 1, 12));
    // bank 0, &1000 write with shadow: web 1 clock, ceb 2 clocks
    applyStimulus(8'h00, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A,
                  mkExp(6, 1'b0, 2, 0, 1, 1'b1, 5'b11100, 8'h00, 1, 12));
    // invalid cycle: fast, no strobes
    applyStimulus(8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                  mkExp(7, 1'b0, 0, 0, 0, 1'b0, 0, 8'h05, 1, 12));
    // bank &0A, &C000 opcode fetch: aliases bank 2
    applyStimulus(8'h0A, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00,
                  mkExp(8, 1'b0, 2, 2, 0, 1'b1, 5'b01011, 8'h0A, 1, 12));
    // bank 0, &8000 read: a15 set, slow despite shadow
    applyStimulus(8'h00, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                  mkExp(9, 1'b1, 0, 0, 0, 1'b0, 0, 8'h00, 1, 12));

    // Start a slow cycle and assert reset in its high phase.
    cpu_d = 8'h00; cpu_a = 16'hFE40; cpu_rnw = 1'b1; cpu_vda = 1'b1; cpu_vpa = 1'b0;
    dec_fe4x = 1'b1; dec_shadow_reg = 1'b0; dec_rom_reg = 1'b0;
    n = 0;
    do begin
      @(negedge hsclk);
      n++;
    end while (!(cpu_phi2 && bbc_cycle) && (n < 200));
    checkOutput("abort.slowHiReached", int'(cpu_phi2 && bbc_cycle), 1);
    #2 resetb = 1'b0;
    #1;
    checkOutput("abort.cpuPhi2", int'(cpu_phi2), 0);
    checkOutput("abort.bbcCycle", int'(bbc_cycle), 0);
    checkOutput("abort.shadowEn", int'(shadow_en), 0);
    checkOutput("abort.romSel", int'(rom_sel), 0);
    checkOutput("abort.ramCeb", int'(ram_ceb), 1);
    repeat (3) @(posedge hsclk);
    #4 resetb = 1'b1;

    // first cycle after reset: bank 3, &4000 write, low phase 2 clocks
    applyStimulus(8'h03, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5,
                  mkExp(10, 1'b0, 2, 0, 1, 1'b1, 5'b01101, 8'h03, 0, 0));
    // bank 0, &3000 read with shadow cleared: now slow
    applyStimulus(8'h00, 16'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                  mkExp(11, 1'b1, 0, 0, 0, 1'b0, 0, 8'h00, 0, 0));

    repeat (4) @(negedge hsclk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
